// File: rtl/axi4s_upsizer_pkg.sv
// Shared types, widths and parity helpers for the 64->256 AXI4-Stream upsizer.
package axi4s_upsizer_pkg;

    localparam int DEF_IN_DATA_WIDTH  = 64;
    localparam int DEF_OUT_DATA_WIDTH = 256;
    localparam int DEF_RATIO          = DEF_OUT_DATA_WIDTH / DEF_IN_DATA_WIDTH;
    localparam int DEF_PAR_SLICE      = 16;
    localparam int DEF_ERR_CNT_W      = 16;

    typedef logic [3:0]   bv4_t;
    typedef logic [15:0]  bv16_t;
    typedef logic [63:0]  bv64_t;
    typedef logic [255:0] bv256_t;

    // One packed wide beat as it travels from the accumulator to the output register.
    typedef struct packed {
        bv256_t      data;
        logic [31:0] keep;
        logic [31:0] strb;
        logic        last;
        bv4_t        id;
        bv4_t        dest;
    } wide_word_t;

    localparam wide_word_t WORD_ZERO = '{data: 256'd0, keep: 32'd0, strb: 32'd0,
                                         last: 1'b0, id: 4'd0, dest: 4'd0};

    // Even parity per 16-bit slice of a wide word.
    function automatic bv16_t calc_parity_t1(input bv256_t d);
        bv16_t p;
        p = 16'd0;
        for (int i = 0; i < 16; i++) begin
            p[i] = ^d[DEF_PAR_SLICE*i +: DEF_PAR_SLICE];
        end
        return p;
    endfunction

    // Even parity per 16-bit slice of a narrow word.
    function automatic bv4_t calc_parity_t2(input bv64_t d);
        bv4_t p;
        p = 4'd0;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[DEF_PAR_SLICE*i +: DEF_PAR_SLICE];
        end
        return p;
    endfunction

endpackage

// File: rtl/axi4s_upsizer_if.sv
// Generic AXI4-Stream bundle; src drives the beat, dst returns tready.
interface axi4_stream_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 4,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;
    logic [USER_W-1:0]     tuser;

    modport src (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                 input  tready);
    modport dst (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                 output tready);
endinterface

// File: rtl/axi4s_upsizer_outreg.sv
// Output holding register for the upsizer: holds one wide beat until the
// consumer accepts it, drives zeros while empty, regenerates slice parity.
module axi4s_upsizer_outreg
    import axi4s_upsizer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  wide_word_t load_word,
    axi4_stream_if.src axis_out
);

    logic       valid_r;
    wide_word_t word_r;

    // Capture a closed word, or empty the register once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            word_r  <= WORD_ZERO;
        end else if (load) begin
            valid_r <= 1'b1;
            word_r  <= load_word;
        end else if (valid_r && axis_out.tready) begin
            valid_r <= 1'b0;
            word_r  <= WORD_ZERO;
        end else begin
            valid_r <= valid_r;
            word_r  <= word_r;
        end
    end

    // Present the held word; every field reads zero while nothing is held.
    always_comb begin
        axis_out.tvalid = 1'b0;
        axis_out.tdata  = 256'd0;
        axis_out.tkeep  = 32'd0;
        axis_out.tstrb  = 32'd0;
        axis_out.tlast  = 1'b0;
        axis_out.tid    = 4'd0;
        axis_out.tdest  = 4'd0;
        axis_out.tuser  = 16'd0;
        if (valid_r) begin
            axis_out.tvalid = 1'b1;
            axis_out.tdata  = word_r.data;
            axis_out.tkeep  = word_r.keep;
            axis_out.tstrb  = word_r.strb;
            axis_out.tlast  = word_r.last;
            axis_out.tid    = word_r.id;
            axis_out.tdest  = word_r.dest;
            axis_out.tuser  = calc_parity_t1(word_r.data);
        end else begin
            axis_out.tvalid = 1'b0;
        end
    end

endmodule

// File: rtl/axi4s_upsizer.sv
// Packs four 64-bit AXI4-Stream beats into one 256-bit beat. An early tlast
// closes a zero-padded partial word. Input slice parity and tid/tdest
// consistency are checked per beat; a one-word pending slot in the
// accumulator absorbs output backpressure.
module axi4s_upsizer
    import axi4s_upsizer_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int PAR_SLICE      = DEF_PAR_SLICE,
    parameter int ERR_CNT_W      = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi4_stream_if.dst           axis_in,
    axi4_stream_if.src           axis_out,
    output logic                 parity_err,
    output logic                 id_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int RATIO     = OUT_DATA_WIDTH / IN_DATA_WIDTH;
    localparam int LANE_W    = $clog2(RATIO);
    localparam int IN_KEEP_W = IN_DATA_WIDTH / 8;
    localparam int IN_PAR_W  = IN_DATA_WIDTH / PAR_SLICE;
    localparam logic [LANE_W-1:0]    LAST_LANE   = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0]    LANE_ZERO   = {LANE_W{1'b0}};
    localparam logic [LANE_W-1:0]    LANE_ONE    = {{(LANE_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    wide_word_t             acc_r;
    logic [LANE_W-1:0]      lane_idx_r;
    logic                   pend_r;
    logic                   parity_err_r;
    logic                   id_err_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;

    wide_word_t             merged_s;
    wide_word_t             load_word_s;
    logic                   load_s;
    logic                   in_fire_s;
    logic                   out_fire_s;
    logic                   complete_s;
    logic                   out_free_s;
    logic                   par_bad_s;
    logic                   id_bad_s;
    logic [IN_PAR_W-1:0]    in_par_s;

    assign axis_in.tready = ~pend_r;
    assign in_fire_s      = axis_in.tvalid & ~pend_r;
    assign out_fire_s     = axis_out.tvalid & axis_out.tready;
    // The output register can take a word on this edge if empty or draining now.
    assign out_free_s     = ~axis_out.tvalid | out_fire_s;
    assign complete_s     = (lane_idx_r == LAST_LANE) | axis_in.tlast;
    assign in_par_s       = calc_parity_t2(axis_in.tdata);
    assign par_bad_s      = (axis_in.tuser != in_par_s);
    assign id_bad_s       = (lane_idx_r != LANE_ZERO) &&
                            ((axis_in.tid != acc_r.id) || (axis_in.tdest != acc_r.dest));

    assign parity_err = parity_err_r;
    assign id_err     = id_err_r;
    assign err_cnt    = err_cnt_r;

    // Accumulator contents as they would be after writing the current beat into its lane.
    always_comb begin
        merged_s = acc_r;
        merged_s.data[IN_DATA_WIDTH*int'(lane_idx_r) +: IN_DATA_WIDTH] = axis_in.tdata;
        merged_s.keep[IN_KEEP_W*int'(lane_idx_r) +: IN_KEEP_W]         = axis_in.tkeep;
        merged_s.strb[IN_KEEP_W*int'(lane_idx_r) +: IN_KEEP_W]         = axis_in.tstrb;
        merged_s.last = axis_in.tlast;
        if (lane_idx_r == LANE_ZERO) begin
            merged_s.id   = axis_in.tid;
            merged_s.dest = axis_in.tdest;
        end else begin
            merged_s.id   = acc_r.id;
            merged_s.dest = acc_r.dest;
        end
    end

    // Choose what, if anything, enters the output register on this edge.
    always_comb begin
        load_s      = 1'b0;
        load_word_s = merged_s;
        if (pend_r) begin
            load_s      = out_fire_s;
            load_word_s = acc_r;
        end else if (in_fire_s && complete_s && out_free_s) begin
            load_s      = 1'b1;
            load_word_s = merged_s;
        end else begin
            load_s      = 1'b0;
            load_word_s = merged_s;
        end
    end

    // Lane packing and the pending slot; a closed word that cannot leave parks in the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= WORD_ZERO;
            lane_idx_r <= LANE_ZERO;
            pend_r     <= 1'b0;
        end else if (pend_r) begin
            if (out_fire_s) begin
                acc_r  <= WORD_ZERO;
                pend_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            if (complete_s) begin
                lane_idx_r <= LANE_ZERO;
                if (out_free_s) begin
                    acc_r <= WORD_ZERO;
                end else begin
                    acc_r  <= merged_s;
                    pend_r <= 1'b1;
                end
            end else begin
                acc_r      <= merged_s;
                lane_idx_r <= lane_idx_r + LANE_ONE;
            end
        end
    end

    // Per-beat error pulses and the saturating parity error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_r <= 1'b0;
            id_err_r     <= 1'b0;
            err_cnt_r    <= {ERR_CNT_W{1'b0}};
        end else begin
            parity_err_r <= in_fire_s & par_bad_s;
            id_err_r     <= in_fire_s & id_bad_s;
            if (in_fire_s && par_bad_s && (err_cnt_r != ERR_CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + ERR_CNT_ONE;
            end
        end
    end

    axi4s_upsizer_outreg u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_word (load_word_s),
        .axis_out  (axis_out)
    );

endmodule

// File: tb/tb_axi4s_upsizer.sv
// Self-checking bench for axi4s_upsizer: directed scenarios plus a random
// stream, checked against a word-level reference model kept in the bench.
module tb_axi4s_upsizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        parity_err;
    logic        id_err;
    logic [15:0] err_cnt;

    int checks = 0;
    int failures = 0;
    int bp_mode = 0;
    int out_count = 0;

    axi4_stream_if #(.DATA_W(64),  .USER_W(4))  in_if ();
    axi4_stream_if #(.DATA_W(256), .USER_W(16)) out_if ();

    axi4s_upsizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axis_in    (in_if),
        .axis_out   (out_if),
        .parity_err (parity_err),
        .id_err     (id_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [31:0]  strb;
        logic         last;
        logic [3:0]   id;
        logic [3:0]   dest;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] m_data = 256'd0;
    logic [31:0]  m_keep = 32'd0;
    logic [31:0]  m_strb = 32'd0;
    logic [3:0]   m_id = 4'd0;
    logic [3:0]   m_dest = 4'd0;
    int           m_lane = 0;
    logic [15:0]  m_cnt = 16'd0;
    logic         exp_perr = 1'b0;
    logic         exp_ider = 1'b0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data = 256'd0;

    function automatic logic [3:0] ref_par4(input logic [63:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    function automatic logic [15:0] ref_par16(input logic [255:0] d);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one narrow beat and return just after the edge that accepts it.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                        input logic l, input logic [3:0] id, input logic [3:0] dest,
                        input logic flip);
        int n;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tstrb  = s;
        in_if.tlast  = l;
        in_if.tid    = id;
        in_if.tdest  = dest;
        in_if.tuser  = ref_par4(d) ^ (flip ? 4'b0100 : 4'b0000);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_if.tready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 256'd1, 256'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 256'(exp_q.size()), 256'd0);
    endtask

    // Output backpressure: 0 = always ready, 1 = stalled, other = random.
    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_if.tready = 1'b1;
                1:       out_if.tready = 1'b0;
                default: out_if.tready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Reference model and output scoreboard, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_lane = 0; m_data = 256'd0; m_keep = 32'd0; m_strb = 32'd0;
                m_cnt = 16'd0; exp_perr = 1'b0; exp_ider = 1'b0; prev_stall = 1'b0;
            end else begin
                chk("parity_err", 256'(parity_err), 256'(exp_perr));
                chk("id_err", 256'(id_err), 256'(exp_ider));
                chk("err_cnt", 256'(err_cnt), 256'(m_cnt));
                if (prev_stall) begin
                    chk("hold_valid", 256'(out_if.tvalid), 256'd1);
                    chk("hold_data", out_if.tdata, prev_data);
                end
                if (out_if.tvalid) begin
                    if (out_if.tready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_out", 256'd1, 256'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", out_if.tdata, e.data);
                            chk("out_keep", 256'(out_if.tkeep), 256'(e.keep));
                            chk("out_strb", 256'(out_if.tstrb), 256'(e.strb));
                            chk("out_last", 256'(out_if.tlast), 256'(e.last));
                            chk("out_id", 256'(out_if.tid), 256'(e.id));
                            chk("out_dest", 256'(out_if.tdest), 256'(e.dest));
                            chk("out_user", 256'(out_if.tuser), 256'(ref_par16(e.data)));
                        end
                        out_count++;
                    end
                end else begin
                    chk("idle_data", out_if.tdata, 256'd0);
                    chk("idle_keep", 256'(out_if.tkeep), 256'd0);
                    chk("idle_user", 256'(out_if.tuser), 256'd0);
                    chk("idle_last", 256'(out_if.tlast), 256'd0);
                end
                prev_stall = out_if.tvalid && !out_if.tready;
                prev_data  = out_if.tdata;
                exp_perr = 1'b0;
                exp_ider = 1'b0;
                if (in_if.tvalid && in_if.tready) begin
                    if (m_lane == 0) begin
                        m_id = in_if.tid; m_dest = in_if.tdest;
                        m_data = 256'd0; m_keep = 32'd0; m_strb = 32'd0;
                    end else begin
                        exp_ider = (in_if.tid != m_id) || (in_if.tdest != m_dest);
                    end
                    exp_perr = (in_if.tuser != ref_par4(in_if.tdata));
                    if (exp_perr && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_data[64*m_lane +: 64] = in_if.tdata;
                    m_keep[8*m_lane +: 8]   = in_if.tkeep;
                    m_strb[8*m_lane +: 8]   = in_if.tstrb;
                    m_lane++;
                    if (m_lane == 4 || in_if.tlast) begin
                        e.data = m_data; e.keep = m_keep; e.strb = m_strb;
                        e.last = in_if.tlast; e.id = m_id; e.dest = m_dest;
                        exp_q.push_back(e);
                        m_lane = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        int base;
        in_if.tvalid = 1'b0; in_if.tdata = 64'd0; in_if.tkeep = 8'd0; in_if.tstrb = 8'd0;
        in_if.tlast = 1'b0; in_if.tid = 4'd0; in_if.tdest = 4'd0; in_if.tuser = 4'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 256'(out_if.tvalid), 256'd0);
        chk("rst_out_data", out_if.tdata, 256'd0);
        chk("rst_in_ready", 256'(in_if.tready), 256'd1);
        chk("rst_err_cnt", 256'(err_cnt), 256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full four-lane word.
        send(64'h1111_1111_1111_1111, 8'hFF, 8'hFF, 1'b0, 4'd3, 4'd1, 1'b0);
        send(64'h2222_2222_2222_2222, 8'hFF, 8'hFF, 1'b0, 4'd3, 4'd1, 1'b0);
        send(64'h3333_3333_3333_3333, 8'hFF, 8'hFF, 1'b0, 4'd3, 4'd1, 1'b0);
        send(64'h4444_4444_4444_4444, 8'hFF, 8'hFF, 1'b1, 4'd3, 4'd1, 1'b0);
        @(negedge clk);
        chk("t1_valid", 256'(out_if.tvalid), 256'd1);
        chk("t1_data", out_if.tdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        chk("t1_keep", 256'(out_if.tkeep), 256'hFFFF_FFFF);
        chk("t1_last", 256'(out_if.tlast), 256'd1);
        chk("t1_user", 256'(out_if.tuser), 256'd0);
        @(posedge clk); #1;

        // Early tlast on lane 1, then a single-lane word.
        send(64'hAAAA_0000_5555_0001, 8'hFF, 8'hFF, 1'b0, 4'd2, 4'd2, 1'b0);
        send(64'hBBBB_0000_6666_0002, 8'hFF, 8'hFF, 1'b1, 4'd2, 4'd2, 1'b0);
        @(negedge clk);
        chk("t2_keep", 256'(out_if.tkeep), 256'h0000_FFFF);
        d = 64'd0;
        chk("t2_upper_zero", 256'(out_if.tdata[255:128]), 256'(d));
        chk("t2_last", 256'(out_if.tlast), 256'd1);
        @(posedge clk); #1;
        send(64'hCCCC_1234_7777_0003, 8'h0F, 8'h0F, 1'b1, 4'd2, 4'd2, 1'b0);
        @(negedge clk);
        chk("t2_lane0_data", 256'(out_if.tdata[63:0]), 256'(64'hCCCC_1234_7777_0003));
        chk("t2_lane0_keep", 256'(out_if.tkeep), 256'h0000_000F);
        @(posedge clk); #1;

        // Sustained output stall during a continuous 12-beat input.
        bp_mode = 1;
        @(posedge clk); #1;
        base = out_count;
        for (int i = 0; i < 8; i++) begin
            send({$urandom, $urandom}, 8'hFF, 8'hFF, 1'b0, 4'd4, 4'd4, 1'b0);
        end
        @(negedge clk);
        chk("t3_in_ready_low", 256'(in_if.tready), 256'd0);
        chk("t3_out_valid", 256'(out_if.tvalid), 256'd1);
        fork
            begin
                repeat (11) @(posedge clk);
                bp_mode = 0;
            end
            begin
                for (int i = 8; i < 12; i++) begin
                    send({$urandom, $urandom}, 8'hFF, 8'hFF, (i == 11), 4'd4, 4'd4, 1'b0);
                end
            end
        join
        drain();
        chk("t3_out_words", 256'(out_count - base), 256'd3);

        // Corrupted parity on lane 1.
        send(64'h0123_4567_89AB_CDEF, 8'hFF, 8'hFF, 1'b0, 4'd1, 4'd0, 1'b0);
        send(64'hFEDC_BA98_7654_3210, 8'hFF, 8'hFF, 1'b0, 4'd1, 4'd0, 1'b1);
        @(negedge clk);
        chk("t4_parity_err", 256'(parity_err), 256'd1);
        chk("t4_err_cnt", 256'(err_cnt), 256'd1);
        @(posedge clk); #1;
        send(64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 8'hFF, 1'b0, 4'd1, 4'd0, 1'b0);
        send(64'h0000_0000_0000_0007, 8'hFF, 8'hFF, 1'b1, 4'd1, 4'd0, 1'b0);
        @(negedge clk);
        chk("t4_pulse_once", 256'(parity_err), 256'd0);
        chk("t4_err_cnt_hold", 256'(err_cnt), 256'd1);
        @(posedge clk); #1;

        // tid mismatch on lane 1.
        send(64'h1000_0000_0000_0001, 8'hFF, 8'hFF, 1'b0, 4'd3, 4'd6, 1'b0);
        send(64'h2000_0000_0000_0002, 8'hFF, 8'hFF, 1'b0, 4'd5, 4'd6, 1'b0);
        @(negedge clk);
        chk("t5_id_err", 256'(id_err), 256'd1);
        @(posedge clk); #1;
        send(64'h3000_0000_0000_0003, 8'hFF, 8'hFF, 1'b0, 4'd3, 4'd6, 1'b0);
        send(64'h4000_0000_0000_0004, 8'hFF, 8'hFF, 1'b1, 4'd3, 4'd6, 1'b0);
        @(negedge clk);
        chk("t5_out_tid", 256'(out_if.tid), 256'd3);
        @(posedge clk); #1;

        // Random stream with random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 160; i++) begin
            send({$urandom, $urandom}, 8'($urandom), 8'($urandom),
                 (i == 159) || ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0) ? 4'd7 : 4'd3, 4'd2,
                 ($urandom_range(0, 11) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        bp_mode = 0;
        drain();

        // Reset in the middle of a word.
        send(64'hDEAD_BEEF_0000_0001, 8'hFF, 8'hFF, 1'b0, 4'd9, 4'd9, 1'b1);
        send(64'hDEAD_BEEF_0000_0002, 8'hFF, 8'hFF, 1'b0, 4'd9, 4'd9, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 256'(out_if.tvalid), 256'd0);
        chk("t6_out_data", out_if.tdata, 256'd0);
        chk("t6_in_ready", 256'(in_if.tready), 256'd1);
        chk("t6_err_cnt", 256'(err_cnt), 256'd0);
        chk("t6_parity_err", 256'(parity_err), 256'd0);
        chk("t6_id_err", 256'(id_err), 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(64'h5151_5151_5151_5151, 8'hFF, 8'hFF, 1'b0, 4'd8, 4'd8, 1'b0);
        send(64'h6262_6262_6262_6262, 8'hFF, 8'hFF, 1'b0, 4'd8, 4'd8, 1'b0);
        send(64'h7373_7373_7373_7373, 8'hFF, 8'hFF, 1'b0, 4'd8, 4'd8, 1'b0);
        send(64'h8484_8484_8484_8484, 8'hFF, 8'hFF, 1'b0, 4'd8, 4'd8, 1'b0);
        @(negedge clk);
        chk("t6_lane0", 256'(out_if.tdata[63:0]), 256'(64'h5151_5151_5151_5151));
        chk("t6_last", 256'(out_if.tlast), 256'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
